// File: rtl/uart_tx_word_fifo.sv
// Transmit word FIFO feeding the UART sender: queues 32-bit words and serialises
// each into bytes (configurable count/order, optional single-byte mode) over an enable/ready handshake.
module uart_tx_word_fifo #(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned WORD_BYTES = 4,
    parameter bit          MSB_FIRST  = 1'b1
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic [31:0]           in_data,
    input  logic                  in_valid,
    input  logic                  in_byte_mode,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic                  busy,
    output logic [7:0]            tx_data,
    output logic                  tx_enable,
    input  logic                  tx_ready
);

    localparam int unsigned DEPTH    = 1 << DEPTH_LOG2;
    localparam int unsigned PW       = DEPTH_LOG2;
    localparam int unsigned CW       = DEPTH_LOG2 + 1;
    localparam logic [1:0]  LAST_IDX = 2'(WORD_BYTES - 1);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GUARD, S_WAIT} state_e;

    logic [32:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          full_q, full_d;

    state_e        state_q;
    logic [31:0]   word_q;
    logic [1:0]    idx_q;
    logic [1:0]    bytes_left_q;
    logic [7:0]    tx_data_q;
    logic          tx_enable_q;

    logic          pop_c;
    logic          push_c;
    logic [32:0]   head_c;
    logic [4:0]    shamt_c;
    logic [7:0]    cur_byte_c;

    // A pop frees a slot in the same cycle, so a full FIFO can still take a push.
    assign pop_c      = (state_q == S_IDLE) && (count_q != '0);
    assign push_c     = in_valid && ((count_q < CW'(DEPTH)) || pop_c);
    assign head_c     = mem_q[rd_ptr_q];
    assign shamt_c    = {idx_q, 3'b000};
    assign cur_byte_c = 8'(word_q >> shamt_c);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push_c && !pop_c) begin
            count_d = count_q + CW'(1);
        end else if (!push_c && pop_c) begin
            count_d = count_q - CW'(1);
        end
        if (in_valid && !push_c) begin
            overflow_d = 1'b1;
        end
        full_d = (count_d == CW'(DEPTH));
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            full_q     <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            full_q     <= full_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= {in_byte_mode, in_data};
        end
    end

    // Serialiser: GUARD gives the sender one cycle to drop ready after a start pulse.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q      <= S_IDLE;
            word_q       <= '0;
            idx_q        <= '0;
            bytes_left_q <= '0;
            tx_data_q    <= '0;
            tx_enable_q  <= 1'b0;
        end else begin
            tx_enable_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pop_c) begin
                        word_q       <= head_c[31:0];
                        bytes_left_q <= head_c[32] ? 2'd0 : LAST_IDX;
                        idx_q        <= (head_c[32] || !MSB_FIRST) ? 2'd0 : LAST_IDX;
                        state_q      <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (tx_ready) begin
                        tx_enable_q <= 1'b1;
                        tx_data_q   <= cur_byte_c;
                        state_q     <= S_GUARD;
                    end
                end
                S_GUARD: begin
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (tx_ready) begin
                        if (bytes_left_q == 2'd0) begin
                            state_q <= S_IDLE;
                        end else begin
                            bytes_left_q <= bytes_left_q - 2'd1;
                            idx_q        <= MSB_FIRST ? (idx_q - 2'd1) : (idx_q + 2'd1);
                            state_q      <= S_SEND;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign full      = full_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign busy      = (state_q != S_IDLE) || (count_q != '0);
    assign tx_data   = tx_data_q;
    assign tx_enable = tx_enable_q;

endmodule

// File: tb/tb_uart_tx_word_fifo.sv
// Directed bench for uart_tx_word_fifo: default instance (4 bytes, MSB first, depth 16)
// plus a 2-byte LSB-first instance.
module tb_uart_tx_word_fifo;

    logic        CLK = 1'b0;
    logic        reset;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_byte_mode;
    logic        full;
    logic [4:0]  count;
    logic        overflow;
    logic        busy;
    logic [7:0]  tx_data;
    logic        tx_enable;
    logic        tx_ready;

    logic [31:0] in_data2;
    logic        in_valid2;
    logic        in_byte_mode2;
    logic        full2;
    logic [4:0]  count2;
    logic        overflow2;
    logic        busy2;
    logic [7:0]  tx_data2;
    logic        tx_enable2;
    logic        tx_ready2;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    logic [7:0] rx_data[$];
    int         rx_cyc[$];
    logic [7:0] rx2_data[$];
    int         rx2_cyc[$];

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    uart_tx_word_fifo #(.DEPTH_LOG2(4), .WORD_BYTES(4), .MSB_FIRST(1'b1)) dut (
        .CLK(CLK), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_byte_mode(in_byte_mode), .full(full), .count(count), .overflow(overflow),
        .busy(busy), .tx_data(tx_data), .tx_enable(tx_enable), .tx_ready(tx_ready)
    );

    uart_tx_word_fifo #(.DEPTH_LOG2(4), .WORD_BYTES(2), .MSB_FIRST(1'b0)) dut2 (
        .CLK(CLK), .reset(reset), .in_data(in_data2), .in_valid(in_valid2),
        .in_byte_mode(in_byte_mode2), .full(full2), .count(count2), .overflow(overflow2),
        .busy(busy2), .tx_data(tx_data2), .tx_enable(tx_enable2), .tx_ready(tx_ready2)
    );

    always @(negedge CLK) begin
        if (tx_enable === 1'b1) begin
            rx_data.push_back(tx_data);
            rx_cyc.push_back(cyc);
        end
        if (tx_enable2 === 1'b1) begin
            rx2_data.push_back(tx_data2);
            rx2_cyc.push_back(cyc);
        end
    end

    function automatic logic [31:0] pat(input int k);
        logic [7:0] b;
        b = 8'(k);
        return {b, 8'hA5, 8'h5A, ~b};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic clear_rx();
        rx_data.delete();
        rx_cyc.delete();
        rx2_data.delete();
        rx2_cyc.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(2);
        vectors++; if (count !== 5'd0)    begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        vectors++; if (full !== 1'b0)     begin errors++; $display("FAIL reset_full: got %b want 0", full); end
        vectors++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        vectors++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (tx_enable !== 1'b0) begin errors++; $display("FAIL reset_tx_enable: got %b want 0", tx_enable); end
        vectors++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
        vectors++; if (busy2 !== 1'b0)    begin errors++; $display("FAIL reset_busy2: got %b want 0", busy2); end
        reset = 1'b0;
    endtask

    task automatic test_msb_word();
        int p;
        logic [7:0] exp_b[4];
        exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
        clear_rx();
        tx_ready     = 1'b1;
        in_data      = 32'h1122_3344;
        in_byte_mode = 1'b0;
        in_valid     = 1'b1;
        tick(1);
        in_valid = 1'b0;
        p = cyc;
        vectors++; if (count !== 5'd1) begin errors++; $display("FAIL msb_count_after_push: got %0d want 1", count); end
        tick(1);
        vectors++; if (count !== 5'd0) begin errors++; $display("FAIL msb_count_after_pop: got %0d want 0", count); end
        tick(11);
        vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL msb_busy_last_wait: got %b want 1", busy); end
        tick(1);
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL msb_busy_done: got %b want 0", busy); end
        tick(3);
        vectors++; if (rx_data.size() != 4) begin errors++; $display("FAIL msb_pulse_count: got %0d want 4", rx_data.size()); end
        for (int i = 0; i < 4 && i < rx_data.size(); i++) begin
            vectors++;
            if (rx_data[i] !== exp_b[i] || rx_cyc[i] != p + 2 + 3 * i) begin
                errors++;
                $display("FAIL msb_byte%0d: got %h@%0d want %h@%0d", i, rx_data[i], rx_cyc[i] - p, exp_b[i], 2 + 3 * i);
            end
        end
    endtask

    task automatic test_byte_mode();
        int p;
        clear_rx();
        tx_ready     = 1'b1;
        in_data      = 32'hDEAD_BEEF;
        in_byte_mode = 1'b1;
        in_valid     = 1'b1;
        tick(1);
        in_valid     = 1'b0;
        in_byte_mode = 1'b0;
        p = cyc;
        tick(12);
        vectors++; if (rx_data.size() != 1) begin errors++; $display("FAIL bytemode_pulse_count: got %0d want 1", rx_data.size()); end
        if (rx_data.size() > 0) begin
            vectors++;
            if (rx_data[0] !== 8'hEF || rx_cyc[0] != p + 2) begin
                errors++;
                $display("FAIL bytemode_byte: got %h@%0d want ef@2", rx_data[0], rx_cyc[0] - p);
            end
        end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL bytemode_busy: got %b want 0", busy); end
    endtask

    task automatic test_overflow();
        logic [7:0] exp;
        do_reset();
        clear_rx();
        tx_ready = 1'b0;
        // Word 0 moves into the serialiser, words 1..16 fill all 16 slots.
        for (int k = 0; k < 17; k++) begin
            in_data  = pat(k);
            in_valid = 1'b1;
            tick(1);
        end
        vectors++; if (full !== 1'b1)     begin errors++; $display("FAIL ovf_full: got %b want 1", full); end
        vectors++; if (count !== 5'd16)   begin errors++; $display("FAIL ovf_count: got %0d want 16", count); end
        vectors++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b want 0", overflow); end
        in_data = pat(17);
        tick(1);
        in_valid = 1'b0;
        vectors++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", overflow); end
        vectors++; if (count !== 5'd16)   begin errors++; $display("FAIL ovf_count_kept: got %0d want 16", count); end
        vectors++; if (rx_data.size() != 0) begin errors++; $display("FAIL ovf_sent_while_not_ready: got %0d want 0", rx_data.size()); end
        tx_ready = 1'b1;
        tick(17 * 13 + 10);
        vectors++; if (rx_data.size() != 68) begin errors++; $display("FAIL ovf_drain_count: got %0d want 68", rx_data.size()); end
        for (int i = 0; i < 68 && i < rx_data.size(); i++) begin
            exp = 8'(pat(i / 4) >> (24 - 8 * (i % 4)));
            vectors++;
            if (rx_data[i] !== exp) begin
                errors++;
                $display("FAIL ovf_drain_byte%0d: got %h want %h", i, rx_data[i], exp);
            end
        end
        vectors++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
        vectors++; if (busy !== 1'b0)     begin errors++; $display("FAIL ovf_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_full_push_pop();
        int n;
        int t;
        bit found;
        do_reset();
        clear_rx();
        tx_ready = 1'b0;
        for (int k = 0; k < 17; k++) begin
            in_data  = pat(32 + k);
            in_valid = 1'b1;
            tick(1);
        end
        in_valid = 1'b0;
        tx_ready = 1'b1;
        n = 0;
        t = 0;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            tick(1);
            if (tx_enable === 1'b1) begin
                n++;
                if (n == 4) begin
                    found = 1'b1;
                    t = cyc;
                end
            end
        end
        vectors++;
        if (!found) begin
            errors++;
            $display("FAIL pp_timeout: got %0d pulses want 4", n);
        end else begin
            tick(2);
            vectors++; if (count !== 5'd16) begin errors++; $display("FAIL pp_count_before: got %0d want 16", count); end
            in_data  = 32'hCAFE_F00D;
            in_valid = 1'b1;
            tick(1);
            in_valid = 1'b0;
            vectors++; if (cyc != t + 3)      begin errors++; $display("FAIL pp_timing: got %0d want %0d", cyc - t, 3); end
            vectors++; if (count !== 5'd16)   begin errors++; $display("FAIL pp_count: got %0d want 16", count); end
            vectors++; if (full !== 1'b1)     begin errors++; $display("FAIL pp_full: got %b want 1", full); end
            vectors++; if (overflow !== 1'b0) begin errors++; $display("FAIL pp_overflow: got %b want 0", overflow); end
        end
        do_reset();
    endtask

    task automatic test_reset_mid_word();
        int p;
        logic [7:0] exp_b[4];
        do_reset();
        clear_rx();
        tx_ready = 1'b1;
        in_data  = 32'hAABB_CCDD;
        in_valid = 1'b1;
        tick(1);
        p = cyc;
        in_data = 32'h1010_1010;
        tick(1);
        in_data = 32'h2020_2020;
        tick(1);
        in_data = 32'h3030_3030;
        tick(1);
        in_valid = 1'b0;
        tick(3);
        vectors++; if (count !== 5'd3) begin errors++; $display("FAIL rst_mid_queued: got %0d want 3", count); end
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        vectors++; if (cyc != p + 7) begin errors++; $display("FAIL rst_mid_timing: got %0d want 7", cyc - p); end
        vectors++; if (count !== 5'd0)     begin errors++; $display("FAIL rst_mid_count: got %0d want 0", count); end
        vectors++; if (busy !== 1'b0)      begin errors++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        vectors++; if (tx_enable !== 1'b0) begin errors++; $display("FAIL rst_mid_tx_enable: got %b want 0", tx_enable); end
        tick(20);
        vectors++; if (rx_data.size() != 2) begin errors++; $display("FAIL rst_mid_pulses: got %0d want 2", rx_data.size()); end
        if (rx_data.size() >= 2) begin
            vectors++;
            if (rx_data[0] !== 8'hAA || rx_data[1] !== 8'hBB) begin
                errors++;
                $display("FAIL rst_mid_bytes: got %h %h want aa bb", rx_data[0], rx_data[1]);
            end
        end
        clear_rx();
        exp_b = '{8'h01, 8'h02, 8'h03, 8'h04};
        in_data  = 32'h0102_0304;
        in_valid = 1'b1;
        tick(1);
        in_valid = 1'b0;
        tick(16);
        vectors++; if (rx_data.size() != 4) begin errors++; $display("FAIL rst_new_pulses: got %0d want 4", rx_data.size()); end
        for (int i = 0; i < 4 && i < rx_data.size(); i++) begin
            vectors++;
            if (rx_data[i] !== exp_b[i]) begin
                errors++;
                $display("FAIL rst_new_byte%0d: got %h want %h", i, rx_data[i], exp_b[i]);
            end
        end
    endtask

    task automatic test_lsb_two_byte();
        int p;
        clear_rx();
        tx_ready2 = 1'b1;
        in_data2  = 32'h0000_ABCD;
        in_valid2 = 1'b1;
        tick(1);
        in_valid2 = 1'b0;
        p = cyc;
        tick(12);
        vectors++; if (rx2_data.size() != 2) begin errors++; $display("FAIL lsb_pulses: got %0d want 2", rx2_data.size()); end
        if (rx2_data.size() >= 2) begin
            vectors++;
            if (rx2_data[0] !== 8'hCD || rx2_cyc[0] != p + 2) begin
                errors++;
                $display("FAIL lsb_byte0: got %h@%0d want cd@2", rx2_data[0], rx2_cyc[0] - p);
            end
            vectors++;
            if (rx2_data[1] !== 8'hAB || rx2_cyc[1] != p + 5) begin
                errors++;
                $display("FAIL lsb_byte1: got %h@%0d want ab@5", rx2_data[1], rx2_cyc[1] - p);
            end
        end
        vectors++; if (busy2 !== 1'b0) begin errors++; $display("FAIL lsb_busy: got %b want 0", busy2); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        in_data       = '0;
        in_valid      = 1'b0;
        in_byte_mode  = 1'b0;
        tx_ready      = 1'b1;
        in_data2      = '0;
        in_valid2     = 1'b0;
        in_byte_mode2 = 1'b0;
        tx_ready2     = 1'b1;
        test_reset();
        test_msb_word();
        test_byte_mode();
        test_overflow();
        test_full_push_pop();
        test_reset_mid_word();
        test_lsb_two_byte();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
